// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU operand sequencer: state/fxn encodings and
// the default debounce length.
package alu_seq_pkg;

  localparam int unsigned ALU_WIDTH               = 6;
  localparam int unsigned STATE_W                 = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 1000000;

  typedef enum logic [STATE_W-1:0] {
    ST_ENTER_A   = 3'd0,
    ST_ENTER_B   = 3'd1,
    ST_ENTER_FXN = 3'd2,
    ST_EXEC      = 3'd3,
    ST_SHOW      = 3'd4
  } state_t;

  localparam logic [2:0] FXN_PASS_A = 3'b000;
  localparam logic [2:0] FXN_PASS_B = 3'b001;
  localparam logic [2:0] FXN_NEG_A  = 3'b010;
  localparam logic [2:0] FXN_NEG_B  = 3'b011;
  localparam logic [2:0] FXN_LT     = 3'b100;
  localparam logic [2:0] FXN_XNOR   = 3'b101;
  localparam logic [2:0] FXN_ADD    = 3'b110;
  localparam logic [2:0] FXN_SUB    = 3'b111;

endpackage

// File: rtl/alu_operand_sequencer_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, consecutive-mismatch debounce
// counter, and a one-cycle pulse on the debounced rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;
  logic          mismatch_c;
  logic          accept_c;

  assign mismatch_c = sync2 != level;
  assign accept_c   = mismatch_c && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= accept_c && sync2;
      // Counter only advances across an unbroken run of mismatching cycles.
      if (accept_c) begin
        level <= sync2;
        cnt   <= '0;
      end else if (mismatch_c) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/alu_operand_sequencer.sv
// Operand/function entry controller for the 6-bit ALU; captures X/OVF for display.
// Build option: define ALU_SEQ_CHAIN_EN to chain results into operand A from SHOW.
module alu_operand_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH           = ALU_WIDTH,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_next,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_fxn,
  input  logic [WIDTH-1:0] alu_x,
  input  logic [1:0]       alu_ovf,
  output logic [WIDTH-1:0] result_q,
  output logic [1:0]       ovf_q,
  output logic             result_valid,
  output logic [2:0]       state_o
);

  logic next_pulse;
  logic clear_pulse;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_next),
    .pulse (next_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn_clear),
    .pulse (clear_pulse)
  );

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] alu_a_d;
  logic [WIDTH-1:0] alu_b_d;
  logic [2:0]       alu_fxn_d;
  logic [WIDTH-1:0] result_d;
  logic [1:0]       ovf_d;
  logic             valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ENTER_A;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_fxn      <= '0;
      result_q     <= '0;
      ovf_q        <= '0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a        <= alu_a_d;
      alu_b        <= alu_b_d;
      alu_fxn      <= alu_fxn_d;
      result_q     <= result_d;
      ovf_q        <= ovf_d;
      result_valid <= valid_d;
    end
  end

  // Next-state and register updates; clear overrides any simultaneous next.
  always_comb begin
    state_d   = state_q;
    alu_a_d   = alu_a;
    alu_b_d   = alu_b;
    alu_fxn_d = alu_fxn;
    result_d  = result_q;
    ovf_d     = ovf_q;
    valid_d   = result_valid;

    if (clear_pulse) begin
      state_d   = ST_ENTER_A;
      alu_a_d   = '0;
      alu_b_d   = '0;
      alu_fxn_d = '0;
      result_d  = '0;
      ovf_d     = '0;
      valid_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ENTER_A: begin
          if (next_pulse) begin
            alu_a_d = sw;
            state_d = ST_ENTER_B;
          end
        end
        ST_ENTER_B: begin
          if (next_pulse) begin
            alu_b_d = sw;
            state_d = ST_ENTER_FXN;
          end
        end
        ST_ENTER_FXN: begin
          if (next_pulse) begin
            alu_fxn_d = sw[2:0];
            valid_d   = 1'b0;
            state_d   = ST_EXEC;
          end
        end
        ST_EXEC: begin
          // ALU inputs have been stable since the previous edge.
          result_d = alu_x;
          ovf_d    = alu_ovf;
          valid_d  = 1'b1;
          state_d  = ST_SHOW;
        end
        ST_SHOW: begin
          if (next_pulse) begin
`ifdef ALU_SEQ_CHAIN_EN
            alu_a_d = result_q;
            state_d = ST_ENTER_B;
`else
            state_d = ST_ENTER_A;
`endif
          end
        end
        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with a behavioural 6-bit ALU model.
module tb_alu_operand_sequencer;
  import alu_seq_pkg::*;

  localparam int unsigned W = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] sw = '0;
  logic         btn_next = 1'b0;
  logic         btn_clear = 1'b0;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_fxn;
  logic [W-1:0] alu_x;
  logic [1:0]   alu_ovf;
  logic [W-1:0] result_q;
  logic [1:0]   ovf_q;
  logic         result_valid;
  logic [2:0]   state_o;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sw           (sw),
    .btn_next     (btn_next),
    .btn_clear    (btn_clear),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_fxn      (alu_fxn),
    .alu_x        (alu_x),
    .alu_ovf      (alu_ovf),
    .result_q     (result_q),
    .ovf_q        (ovf_q),
    .result_valid (result_valid),
    .state_o      (state_o)
  );

  // Behavioural ALU: ovf[0] = signed overflow, ovf[1] = carry-out.
  always_comb begin
    logic [W:0] wide;
    wide    = '0;
    alu_x   = '0;
    alu_ovf = '0;
    case (alu_fxn)
      FXN_PASS_A: alu_x = alu_a;
      FXN_PASS_B: alu_x = alu_b;
      FXN_NEG_A:  alu_x = W'(-alu_a);
      FXN_NEG_B:  alu_x = W'(-alu_b);
      FXN_LT:     alu_x = W'($signed(alu_a) < $signed(alu_b));
      FXN_XNOR:   alu_x = ~(alu_a ^ alu_b);
      FXN_ADD: begin
        wide       = {1'b0, alu_a} + {1'b0, alu_b};
        alu_x      = wide[W-1:0];
        alu_ovf[1] = wide[W];
        alu_ovf[0] = (alu_a[W-1] == alu_b[W-1]) && (wide[W-1] != alu_a[W-1]);
      end
      default: begin
        wide       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_x      = wide[W-1:0];
        alu_ovf[1] = wide[W];
        alu_ovf[0] = (alu_a[W-1] != alu_b[W-1]) && (wide[W-1] != alu_a[W-1]);
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press_next(input logic [W-1:0] v);
    sw = v;
    btn_next = 1'b1;
    tick(10);
    btn_next = 1'b0;
    tick(10);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    tick(10);
    btn_clear = 1'b0;
    tick(10);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"}, 32'(alu_a), 32'd0);
    check({tag, "_b"}, 32'(alu_b), 32'd0);
    check({tag, "_fxn"}, 32'(alu_fxn), 32'd0);
    check({tag, "_res"}, 32'(result_q), 32'd0);
    check({tag, "_ovf"}, 32'(ovf_q), 32'd0);
    check({tag, "_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_state"}, 32'(state_o), 32'd0);
  endtask

  initial begin
    // Power-on reset
    tick(3);
    check_all_zero("por");
    rst_n = 1'b1;
    tick(2);

    // 5 + 3 with fxn-latency tracking
    press_next(6'd5);
    check("t2_a", 32'(alu_a), 32'd5);
    check("t2_state_b", 32'(state_o), 32'd1);
    press_next(6'd3);
    check("t2_b", 32'(alu_b), 32'd3);
    check("t2_state_fxn", 32'(state_o), 32'd2);
    sw = 6'b000110;
    btn_next = 1'b1;
    tick(6);
    check("t2_pre_pulse_state", 32'(state_o), 32'd2);
    tick(1);
    check("t2_exec_state", 32'(state_o), 32'd3);
    check("t2_fxn", 32'(alu_fxn), 32'd6);
    check("t2_exec_valid", 32'(result_valid), 32'd0);
    tick(1);
    check("t2_show_state", 32'(state_o), 32'd4);
    check("t2_res", 32'(result_q), 32'd8);
    check("t2_ovf", 32'(ovf_q), 32'd0);
    check("t2_valid", 32'(result_valid), 32'd1);
    tick(2);
    btn_next = 1'b0;
    tick(10);
    check("t2_hold_state", 32'(state_o), 32'd4);

    // Next from SHOW: chain or return to ENTER_A
    press_next(6'h2A);
`ifdef ALU_SEQ_CHAIN_EN
    check("t6_state", 32'(state_o), 32'd1);
    check("t6_a", 32'(alu_a), 32'd8);
`else
    check("t6_state", 32'(state_o), 32'd0);
    check("t6_a", 32'(alu_a), 32'd5);
`endif
    check("t6_res_kept", 32'(result_q), 32'd8);
    check("t6_valid_kept", 32'(result_valid), 32'd1);

    press_clear();
    check_all_zero("clr");

    // Signed overflow on add, then subtract wrap
    press_next(6'b011111);
    press_next(6'b000001);
    press_next(6'b000110);
    check("t3_add_state", 32'(state_o), 32'd4);
    check("t3_add_res", 32'(result_q), 32'b100000);
    check("t3_add_ovf", 32'(ovf_q), 32'b01);
    check("t3_add_valid", 32'(result_valid), 32'd1);
    press_clear();
    press_next(6'b000000);
    press_next(6'b000001);
    press_next(6'b000111);
    check("t3_sub_res", 32'(result_q), 32'b111111);
    check("t3_sub_state", 32'(state_o), 32'd4);
    press_clear();

    // Bouncing button gives exactly one advance
    sw = 6'd21;
    for (int i = 0; i < 10; i++) begin
      btn_next = ~btn_next;
      tick(2);
    end
    check("t4_bounce_state", 32'(state_o), 32'd0);
    btn_next = 1'b1;
    tick(10);
    check("t4_one_adv", 32'(state_o), 32'd1);
    check("t4_a", 32'(alu_a), 32'd21);
    tick(50);
    check("t4_held", 32'(state_o), 32'd1);
    btn_next = 1'b0;
    tick(10);
    check("t4_release", 32'(state_o), 32'd1);

    // Simultaneous clear and next in ENTER_B
    press_clear();
    press_next(6'd9);
    check("t5_pre_state", 32'(state_o), 32'd1);
    check("t5_pre_a", 32'(alu_a), 32'd9);
    btn_next  = 1'b1;
    btn_clear = 1'b1;
    tick(10);
    btn_next  = 1'b0;
    btn_clear = 1'b0;
    tick(10);
    check("t5_state", 32'(state_o), 32'd0);
    check("t5_a", 32'(alu_a), 32'd0);
    check("t5_b", 32'(alu_b), 32'd0);

    // Asynchronous reset while in SHOW
    press_next(6'd2);
    press_next(6'd3);
    press_next(6'b000110);
    check("t1_pre_state", 32'(state_o), 32'd4);
    check("t1_pre_res", 32'(result_q), 32'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_show");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check_all_zero("rst_rel");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
